// File: rtl/vx_branch_join.sv
// vx_branch_join
//   Joins per-warp branch issue with branch resolutions coming back from the
//   ALU blocks. A warp that issued a branch is stalled until its branch
//   resolves; a taken branch then offers a PC redirect to the scheduler,
//   arbitrated round-robin across warps.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   issue_valid/wid      scheduler issued a branch for warp issue_wid
//   br_valid/wid/taken/dest
//                        per-ALU-block resolution strobes (packed per block)
//   redir_valid/ready    redirect handshake towards the scheduler
//   redir_wid/dest       warp and target PC of the offered redirect
//   stall_mask           bit w set while warp w is not idle
//   err                  sticky protocol-error flag
//   perf_branches/taken  accepted-resolution and taken-resolution counters
module vx_branch_join #(
    parameter int CORE_ID    = 0,
    parameter int NUM_BLOCKS = 2,
    parameter int NUM_WARPS  = 8,
    parameter int PC_BITS    = 32,
    parameter int NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             issue_valid,
    input  logic [NW_WIDTH-1:0]              issue_wid,
    input  logic [NUM_BLOCKS-1:0]            br_valid,
    input  logic [NUM_BLOCKS*NW_WIDTH-1:0]   br_wid,
    input  logic [NUM_BLOCKS-1:0]            br_taken,
    input  logic [NUM_BLOCKS*PC_BITS-1:0]    br_dest,
    output logic                             redir_valid,
    input  logic                             redir_ready,
    output logic [NW_WIDTH-1:0]              redir_wid,
    output logic [PC_BITS-1:0]               redir_dest,
    output logic [NUM_WARPS-1:0]             stall_mask,
    output logic                             err,
    output logic [31:0]                      perf_branches,
    output logic [31:0]                      perf_taken
);

    // CORE_ID only tags instances for tracing; it has no effect on logic.
    if (CORE_ID < 0) begin : g_core_id_negative
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_BR  = 2'd1,
        ST_REDIRECT = 2'd2
    } warp_state_e;

    warp_state_e         state_q [NUM_WARPS];
    warp_state_e         state_d [NUM_WARPS];
    logic [PC_BITS-1:0]  dest_q  [NUM_WARPS];
    logic [PC_BITS-1:0]  dest_d  [NUM_WARPS];

    logic [NW_WIDTH-1:0] ptr_q, ptr_d;
    logic                hold_q, hold_d;
    logic [NW_WIDTH-1:0] hold_wid_q, hold_wid_d;
    logic                err_q, err_d;
    logic [31:0]         perf_br_q, perf_br_d;
    logic [31:0]         perf_tk_q, perf_tk_d;

    logic                grant_found;
    logic [NW_WIDTH-1:0] grant_wid;
    logic [NW_WIDTH-1:0] rr_idx;
    logic                fire;

    logic [NUM_WARPS-1:0] claimed;
    logic [NW_WIDTH-1:0]  res_wid;
    logic [31:0]          n_res;
    logic [31:0]          n_taken;

    // Redirect selection. Once an offer is stalled by !redir_ready it is
    // latched (hold_q) so a warp that enters REDIRECT with higher rotation
    // priority cannot change the offer until it fires.
    always_comb begin
        grant_found = 1'b0;
        grant_wid   = '0;
        rr_idx      = '0;
        if (hold_q) begin
            grant_found = (state_q[hold_wid_q] == ST_REDIRECT);
            grant_wid   = hold_wid_q;
        end else begin
            for (int unsigned i = 0; i < NUM_WARPS; i++) begin
                rr_idx = NW_WIDTH'((32'(ptr_q) + i) % NUM_WARPS);
                if (!grant_found && state_q[rr_idx] == ST_REDIRECT) begin
                    grant_found = 1'b1;
                    grant_wid   = rr_idx;
                end
            end
        end
    end

    assign redir_valid   = grant_found;
    assign redir_wid     = grant_wid;
    assign redir_dest    = dest_q[grant_wid];
    assign fire          = grant_found && redir_ready;
    assign err           = err_q;
    assign perf_branches = perf_br_q;
    assign perf_taken    = perf_tk_q;

    always_comb begin
        stall_mask = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            stall_mask[w] = (state_q[w] != ST_IDLE);
        end
    end

    // Next state. Resolutions and issue are both judged against the current
    // registered state, so a same-cycle issue to a warp that is resolving
    // always sees WAIT_BR and is rejected.
    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        err_d      = err_q;
        ptr_d      = ptr_q;
        claimed    = '0;
        res_wid    = '0;
        n_res      = '0;
        n_taken    = '0;
        hold_d     = grant_found && !redir_ready;
        hold_wid_d = grant_wid;

        // Lowest block index wins when several target the same warp.
        for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
            if (br_valid[b]) begin
                res_wid = br_wid[b*NW_WIDTH +: NW_WIDTH];
                if (claimed[res_wid]) begin
                    err_d = 1'b1;
                end else begin
                    claimed[res_wid] = 1'b1;
                    if (state_q[res_wid] == ST_WAIT_BR) begin
                        n_res = n_res + 32'd1;
                        if (br_taken[b]) begin
                            state_d[res_wid] = ST_REDIRECT;
                            dest_d[res_wid]  = br_dest[b*PC_BITS +: PC_BITS];
                            n_taken          = n_taken + 32'd1;
                        end else begin
                            state_d[res_wid] = ST_IDLE;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        end

        if (fire) begin
            state_d[grant_wid] = ST_IDLE;
            ptr_d = (grant_wid == NW_WIDTH'(NUM_WARPS - 1)) ? '0 : grant_wid + 1'b1;
        end

        if (issue_valid) begin
            if (state_q[issue_wid] == ST_IDLE) begin
                state_d[issue_wid] = ST_WAIT_BR;
            end else begin
                err_d = 1'b1;
            end
        end

        perf_br_d = perf_br_q + n_res;
        perf_tk_d = perf_tk_q + n_taken;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= ST_IDLE;
                dest_q[w]  <= '0;
            end
            ptr_q      <= '0;
            hold_q     <= 1'b0;
            hold_wid_q <= '0;
            err_q      <= 1'b0;
            perf_br_q  <= '0;
            perf_tk_q  <= '0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            hold_wid_q <= hold_wid_d;
            err_q      <= err_d;
            perf_br_q  <= perf_br_d;
            perf_tk_q  <= perf_tk_d;
        end
    end

endmodule

// File: tb/tb_vx_branch_join.sv
module tb_vx_branch_join;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [2:0]  issue_wid;
    logic [1:0]  br_valid;
    logic [5:0]  br_wid;
    logic [1:0]  br_taken;
    logic [63:0] br_dest;
    logic        redir_valid;
    logic        redir_ready;
    logic [2:0]  redir_wid;
    logic [31:0] redir_dest;
    logic [7:0]  stall_mask;
    logic        err;
    logic [31:0] perf_branches;
    logic [31:0] perf_taken;

    int checks = 0;
    int errors = 0;
    logic sb_en = 1'b0;

    typedef struct {
        logic [2:0]  wid;
        logic [31:0] dest;
    } redir_t;
    redir_t sb_q[$];

    typedef struct {
        logic        iv;
        logic [2:0]  iw;
        logic [1:0]  bv;
        logic [2:0]  bw0;
        logic [2:0]  bw1;
        logic [1:0]  bt;
        logic [31:0] bd0;
        logic [31:0] bd1;
        logic        rdy;
        logic        e_valid;
        logic [2:0]  e_wid;
        logic [31:0] e_dest;
        logic [7:0]  e_stall;
        logic        e_err;
    } vec_t;

    vx_branch_join #(
        .CORE_ID    (0),
        .NUM_BLOCKS (2),
        .NUM_WARPS  (8),
        .PC_BITS    (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_wid     (issue_wid),
        .br_valid      (br_valid),
        .br_wid        (br_wid),
        .br_taken      (br_taken),
        .br_dest       (br_dest),
        .redir_valid   (redir_valid),
        .redir_ready   (redir_ready),
        .redir_wid     (redir_wid),
        .redir_dest    (redir_dest),
        .stall_mask    (stall_mask),
        .err           (err),
        .perf_branches (perf_branches),
        .perf_taken    (perf_taken)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every fire seen by the scoreboard must match the next predicted grant.
    always @(negedge clk) begin
        if (sb_en && !reset && redir_valid && redir_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_fire: got wid %0d, expected no fire", redir_wid);
            end else begin
                redir_t e;
                e = sb_q.pop_front();
                check("sb_fire_wid", 32'(redir_wid), 32'(e.wid));
                check("sb_fire_dest", redir_dest, e.dest);
            end
        end
    end

    function automatic vec_t mk(
        input logic iv, input logic [2:0] iw,
        input logic [1:0] bv, input logic [2:0] bw0, input logic [2:0] bw1,
        input logic [1:0] bt, input logic [31:0] bd0, input logic [31:0] bd1,
        input logic rdy, input logic ev, input logic [2:0] ew,
        input logic [31:0] ed, input logic [7:0] es, input logic ee);
        vec_t v;
        v.iv = iv; v.iw = iw; v.bv = bv; v.bw0 = bw0; v.bw1 = bw1;
        v.bt = bt; v.bd0 = bd0; v.bd1 = bd1; v.rdy = rdy;
        v.e_valid = ev; v.e_wid = ew; v.e_dest = ed; v.e_stall = es; v.e_err = ee;
        return v;
    endfunction

    task automatic idle_inputs();
        issue_valid = 1'b0;
        issue_wid   = '0;
        br_valid    = '0;
        br_wid      = '0;
        br_taken    = '0;
        br_dest     = '0;
        redir_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic issue(input logic [2:0] w);
        idle_inputs();
        issue_valid = 1'b1;
        issue_wid   = w;
        step();
    endtask

    task automatic resolve0(input logic [2:0] w, input logic tk, input logic [31:0] d, input logic rdy);
        idle_inputs();
        br_valid    = 2'b01;
        br_wid      = {3'd0, w};
        br_taken    = {1'b0, tk};
        br_dest     = {32'd0, d};
        redir_ready = rdy;
        step();
    endtask

    vec_t tbl[11];

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        check("async_reset_valid", 32'(redir_valid), 32'd0);
        check("async_reset_stall", 32'(stall_mask), 32'd0);
        do_reset();
        check("reset_valid", 32'(redir_valid), 32'd0);
        check("reset_stall", 32'(stall_mask), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_perf_br", perf_branches, 32'd0);
        check("reset_perf_tk", perf_taken, 32'd0);

        // Table: state seen just after each clock edge.
        tbl[0]  = mk(1, 2, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 8'h04, 0);
        tbl[1]  = mk(0, 0, 2'b01, 2, 0, 2'b01, 32'h400, 0, 0, 1, 2, 32'h400, 8'h04, 0);
        tbl[2]  = mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 8'h00, 0);
        tbl[3]  = mk(1, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 8'h02, 0);
        tbl[4]  = mk(0, 0, 2'b10, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        tbl[5]  = mk(1, 5, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 8'h20, 0);
        tbl[6]  = mk(0, 0, 2'b11, 5, 5, 2'b11, 32'h10, 32'h20, 0, 1, 5, 32'h10, 8'h20, 1);
        tbl[7]  = mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 8'h00, 1);
        tbl[8]  = mk(0, 0, 2'b01, 4, 0, 2'b01, 32'h44, 0, 0, 0, 0, 0, 8'h00, 1);
        tbl[9]  = mk(1, 4, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 8'h10, 1);
        tbl[10] = mk(1, 4, 2'b01, 4, 0, 2'b00, 0, 0, 0, 0, 0, 0, 8'h00, 1);

        for (int i = 0; i < 11; i++) begin
            issue_valid = tbl[i].iv;
            issue_wid   = tbl[i].iw;
            br_valid    = tbl[i].bv;
            br_wid      = {tbl[i].bw1, tbl[i].bw0};
            br_taken    = tbl[i].bt;
            br_dest     = {tbl[i].bd1, tbl[i].bd0};
            redir_ready = tbl[i].rdy;
            step();
            check($sformatf("v%0d_valid", i), 32'(redir_valid), 32'(tbl[i].e_valid));
            check($sformatf("v%0d_stall", i), 32'(stall_mask), 32'(tbl[i].e_stall));
            check($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].e_err));
            if (tbl[i].e_valid) begin
                check($sformatf("v%0d_wid", i), 32'(redir_wid), 32'(tbl[i].e_wid));
                check($sformatf("v%0d_dest", i), redir_dest, tbl[i].e_dest);
            end
        end
        idle_inputs();
        check("tbl_perf_br", perf_branches, 32'd4);
        check("tbl_perf_tk", perf_taken, 32'd2);

        // Round-robin: warps 0,1,3 blocked; 0 and 3 resolve together, then 1.
        do_reset();
        sb_en = 1'b1;
        issue(3'd0);
        issue(3'd1);
        issue(3'd3);
        check("rr_stall_blocked", 32'(stall_mask), 32'h0B);
        sb_q.push_back('{wid: 3'd0, dest: 32'h100});
        sb_q.push_back('{wid: 3'd1, dest: 32'h180});
        sb_q.push_back('{wid: 3'd3, dest: 32'h300});
        idle_inputs();
        br_valid = 2'b11; br_wid = {3'd3, 3'd0}; br_taken = 2'b11;
        br_dest = {32'h300, 32'h100}; redir_ready = 1'b1;
        step();
        check("rr_first_wid", 32'(redir_wid), 32'd0);
        resolve0(3'd1, 1'b1, 32'h180, 1'b1);
        check("rr_stall_after_first", 32'(stall_mask), 32'h0A);
        idle_inputs();
        redir_ready = 1'b1;
        step();
        step();
        idle_inputs();
        step();
        check("rr_stall_done", 32'(stall_mask), 32'h00);
        check("rr_valid_done", 32'(redir_valid), 32'd0);
        check("rr_sb_empty", 32'(sb_q.size()), 32'd0);
        check("rr_err", 32'(err), 32'd0);
        check("rr_perf_br", perf_branches, 32'd3);
        check("rr_perf_tk", perf_taken, 32'd3);

        // Stalled offer for warp 6 stays put even when warp 1 (ahead in
        // rotation) enters REDIRECT; reset then withdraws it asynchronously.
        do_reset();
        issue(3'd6);
        resolve0(3'd6, 1'b1, 32'h666, 1'b0);
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            if (c == 0) begin
                issue_valid = 1'b1; issue_wid = 3'd1;
            end else if (c == 1) begin
                br_valid = 2'b01; br_wid = {3'd0, 3'd1}; br_taken = 2'b01;
                br_dest = {32'd0, 32'h111};
            end
            check($sformatf("hold%0d_valid", c), 32'(redir_valid), 32'd1);
            check($sformatf("hold%0d_wid", c), 32'(redir_wid), 32'd6);
            check($sformatf("hold%0d_dest", c), redir_dest, 32'h666);
            step();
        end
        check("hold_stall", 32'(stall_mask), 32'h42);
        idle_inputs();
        br_valid = 2'b01; br_wid = {3'd0, 3'd1}; br_taken = 2'b01;
        issue_valid = 1'b1; issue_wid = 3'd0;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(redir_valid), 32'd0);
        check("async_rst_stall", 32'(stall_mask), 32'd0);
        check("async_rst_err", 32'(err), 32'd0);
        check("async_rst_perf_br", perf_branches, 32'd0);
        step();
        idle_inputs();
        reset = 1'b0;
        step();
        check("post_rst_stall", 32'(stall_mask), 32'd0);
        check("post_rst_valid", 32'(redir_valid), 32'd0);

        // Double issue to a blocked warp.
        do_reset();
        issue(3'd3);
        issue(3'd3);
        check("dbl_issue_stall", 32'(stall_mask), 32'h08);
        check("dbl_issue_err", 32'(err), 32'd1);

        // Issue and resolution for the same warp in one cycle.
        do_reset();
        issue(3'd2);
        sb_q.push_back('{wid: 3'd2, dest: 32'h200});
        idle_inputs();
        issue_valid = 1'b1; issue_wid = 3'd2;
        br_valid = 2'b01; br_wid = {3'd0, 3'd2}; br_taken = 2'b01;
        br_dest = {32'd0, 32'h200};
        step();
        check("same_cyc_valid", 32'(redir_valid), 32'd1);
        check("same_cyc_wid", 32'(redir_wid), 32'd2);
        check("same_cyc_err", 32'(err), 32'd1);
        idle_inputs();
        redir_ready = 1'b1;
        step();
        check("same_cyc_stall", 32'(stall_mask), 32'd0);

        // Issue in the same cycle as the warp's fire is rejected.
        do_reset();
        issue(3'd7);
        sb_q.push_back('{wid: 3'd7, dest: 32'h70});
        resolve0(3'd7, 1'b1, 32'h70, 1'b0);
        idle_inputs();
        redir_ready = 1'b1; issue_valid = 1'b1; issue_wid = 3'd7;
        step();
        check("fire_issue_stall", 32'(stall_mask), 32'd0);
        check("fire_issue_err", 32'(err), 32'd1);

        // Issue the cycle after the fire is accepted.
        do_reset();
        issue(3'd7);
        sb_q.push_back('{wid: 3'd7, dest: 32'h70});
        resolve0(3'd7, 1'b1, 32'h70, 1'b0);
        idle_inputs();
        redir_ready = 1'b1;
        step();
        issue(3'd7);
        idle_inputs();
        check("reissue_stall", 32'(stall_mask), 32'h80);
        check("reissue_err", 32'(err), 32'd0);
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);
        sb_en = 1'b0;

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
